mram_responder: RTL and testbench

//  Cycle-based, synthesizable MRAM target that answers the active-low async-SRAM-style strobes from the
//  SPS burst control path (ce_n/we_n/oe_n/lb_n/ub_n plus parallel addr/data). Stands in for the external

---
 rtl/mram_if.sv | 32 +++
 rtl/mram_responder.sv | 182 ++++++++++++++++++
 tb/tb_mram_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mram_if.sv
// Bus between the SPS burst controller (master) and the MRAM responder (slave).
//
// Handshake: there is no valid/ready pair. The master holds active-low strobes
// (ce_n/we_n/oe_n/lb_n/ub_n) with addr/din, and the slave samples them on every
// rising clk. A write is taken on the first edge that sees ce_n=0 & we_n=0. A read
// is started on the first edge that sees ce_n=0 & we_n=1 & oe_n=0. The slave then
// raises dout_valid and holds dout until the master releases ce_n or oe_n.
interface mram_if;
  logic [19:0] addr;
  logic [15:0] din;
  logic        ce_n;
  logic        we_n;
  logic        oe_n;
  logic        lb_n;
  logic        ub_n;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic        proto_err;

  modport master (
    output addr, din, ce_n, we_n, oe_n, lb_n, ub_n,
    input  dout, dout_valid, busy, wr_cnt, rd_cnt, proto_err
  );

  modport slave (
    input  addr, din, ce_n, we_n, oe_n, lb_n, ub_n,
    output dout, dout_valid, busy, wr_cnt, rd_cnt, proto_err
  );
endinterface

// File: rtl/mram_responder.sv
// mram_responder: cycle-based stand-in for the external MRAM. It answers the
// async-SRAM-style strobes, stores words in internal RAM, and returns read data
// with a fixed latency of READ_LATENCY clocks (legal range 1..15).
// Optional protocol checker: define MRAM_RESP_ERRCHK_EN to build the sticky
// proto_err logic. When the macro is undefined, proto_err is tied to 0.
// Address bits [19:MEM_AW] are ignored, so the RAM aliases across the upper space.
module mram_responder #(
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  mram_if.slave       bus_if,
  output logic [1:0]  state_o
);

  localparam int          DEPTH    = 1 << MEM_AW;
  localparam logic [3:0]  LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_HOLD  = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RD_DRIVE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic [MEM_AW-1:0] rd_addr_q;
  logic              rd_lb_n_q, rd_ub_n_q;
  logic [15:0]       dout_q;
  logic              dout_valid_q;
  logic [15:0]       wr_cnt_q, rd_cnt_q;
  logic [15:0]       mem [0:DEPTH-1];

  logic              wr_req, rd_req, rd_hold;
  logic              wr_commit, rd_enter;
  logic [MEM_AW-1:0] wr_addr;
  logic [15:0]       rd_word, rd_masked;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus_if.addr[19:MEM_AW];
  assign wr_addr          = bus_if.addr[MEM_AW-1:0];

  // Strobe decode: a write takes priority over a read when both are asserted.
  always_comb begin
    wr_req    = !bus_if.ce_n && !bus_if.we_n;
    rd_req    = !bus_if.ce_n &&  bus_if.we_n && !bus_if.oe_n;
    rd_hold   = !bus_if.ce_n && !bus_if.oe_n;
    wr_commit = (state_q == S_IDLE) && wr_req;
    rd_enter  = (state_d == S_RD_DRIVE) && (state_q != S_RD_DRIVE);
  end

  // FSM state register; a reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lat_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // FSM next state, including the read latency countdown.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          state_d = S_WR_HOLD;
        end else if (rd_req) begin
          lat_d   = LAT_INIT;
          state_d = (READ_LATENCY == 1) ? S_RD_DRIVE : S_RD_WAIT;
        end
      end
      S_WR_HOLD: begin
        if (bus_if.ce_n || bus_if.we_n) state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        if (!rd_hold) begin
          state_d = S_IDLE;
        end else if (lat_q == 4'd1) begin
          state_d = S_RD_DRIVE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_RD_DRIVE: begin
        if (!rd_hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy and the debug view of the state.
  always_comb begin
    bus_if.busy = (state_q != S_IDLE);
    state_o     = state_q;
  end

  // Read data path. The RAM word is taken from the address latched at read
  // start. Disabled byte lanes are forced to zero.
  always_comb begin
    rd_word   = mem[rd_addr_q];
    rd_masked = {rd_ub_n_q ? 8'h00 : rd_word[15:8],
                 rd_lb_n_q ? 8'h00 : rd_word[7:0]};
  end

  // Read latch, output register and access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q    <= '0;
      rd_lb_n_q    <= 1'b1;
      rd_ub_n_q    <= 1'b1;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      wr_cnt_q     <= 16'h0000;
      rd_cnt_q     <= 16'h0000;
    end else begin
      if ((state_q == S_IDLE) && rd_req) begin
        rd_addr_q <= wr_addr;
        rd_lb_n_q <= bus_if.lb_n;
        rd_ub_n_q <= bus_if.ub_n;
      end
      if ((state_q == S_RD_DRIVE) && rd_hold) begin
        dout_q       <= rd_masked;
        dout_valid_q <= 1'b1;
      end else begin
        dout_q       <= 16'h0000;
        dout_valid_q <= 1'b0;
      end
      if (wr_commit) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rd_enter)  rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  // RAM write with per-lane enables. The RAM is not cleared by reset, and a
  // write cannot commit while reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_commit && !rst) begin
      if (!bus_if.lb_n) mem[wr_addr][7:0]  <= bus_if.din[7:0];
      if (!bus_if.ub_n) mem[wr_addr][15:8] <= bus_if.din[15:8];
    end
  end

  assign bus_if.dout       = dout_q;
  assign bus_if.dout_valid = dout_valid_q;
  assign bus_if.wr_cnt     = wr_cnt_q;
  assign bus_if.rd_cnt     = rd_cnt_q;

`ifdef MRAM_RESP_ERRCHK_EN
  logic we_n_q;
  logic proto_err_q;
  logic err_d;

  // Protocol violations: we and oe both asserted, we_n falling during a read,
  // or an access that starts with both byte lanes disabled.
  always_comb begin
    err_d = (!bus_if.ce_n && !bus_if.we_n && !bus_if.oe_n)
         || (((state_q == S_RD_WAIT) || (state_q == S_RD_DRIVE)) && we_n_q && !bus_if.we_n)
         || ((state_q == S_IDLE) && (wr_req || rd_req) && bus_if.lb_n && bus_if.ub_n);
  end

  // Sticky error flag plus the previous we_n value for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_n_q      <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      we_n_q <= bus_if.we_n;
      if (err_d) proto_err_q <= 1'b1;
    end
  end

  assign bus_if.proto_err = proto_err_q;
`else
  assign bus_if.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mram_responder.sv
// Directed bench for mram_responder (MEM_AW=10, READ_LATENCY=3).
module tb_mram_responder;

  localparam int RD_LAT = 3;
`ifdef MRAM_RESP_ERRCHK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  dut_state;
  mram_if      bus_if();

  int          n_checks;
  int          n_fail;
  int          exp_wr;
  int          exp_rd;
  logic [15:0] exp_q[$];

  mram_responder #(.MEM_AW(10), .READ_LATENCY(RD_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_if  (bus_if),
    .state_o (dut_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks (inputs change on the falling edge) ----
  task automatic bus_release();
    bus_if.ce_n = 1'b1;
    bus_if.we_n = 1'b1;
    bus_if.oe_n = 1'b1;
    bus_if.lb_n = 1'b1;
    bus_if.ub_n = 1'b1;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic lb,
                          input logic ub, input int hold, input logic oe);
    @(negedge clk);
    bus_if.addr = a;
    bus_if.din  = d;
    bus_if.lb_n = lb;
    bus_if.ub_n = ub;
    bus_if.oe_n = oe;
    bus_if.ce_n = 1'b0;
    bus_if.we_n = 1'b0;
    repeat (hold) @(negedge clk);
    check("wr_busy", 32'(bus_if.busy), 32'd1);
    bus_release();
    @(negedge clk);
    check("wr_idle", 32'(bus_if.busy), 32'd0);
    exp_wr++;
  endtask

  // Starts a read and leaves the strobes asserted. Checks the data against the
  // scoreboard and returns the latency measured in edges after the start edge.
  task automatic do_read(input logic [19:0] a, input logic lb, input logic ub, output int lat);
    int cyc;
    logic [15:0] exp_d;
    @(negedge clk);
    bus_if.addr = a;
    bus_if.lb_n = lb;
    bus_if.ub_n = ub;
    bus_if.we_n = 1'b1;
    bus_if.ce_n = 1'b0;
    bus_if.oe_n = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus_if.dout_valid && cyc < 20);
    lat = cyc - 1;
    if (!bus_if.dout_valid) check("rd_valid_timeout", 32'd0, 32'd1);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("rd_data", 32'(bus_if.dout), 32'(exp_d));
    exp_rd++;
  endtask

  task automatic rd_release();
    bus_release();
    @(negedge clk);
    check("rel_dout", 32'(bus_if.dout), 32'd0);
    check("rel_valid", 32'(bus_if.dout_valid), 32'd0);
    check("rel_busy", 32'(bus_if.busy), 32'd0);
  endtask

  // ---- directed sequence ----
  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;
    exp_wr   = 0;
    exp_rd   = 0;
    bus_if.addr = 20'h0;
    bus_if.din  = 16'h0;
    bus_release();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_dout", 32'(bus_if.dout), 32'd0);
    check("rst_valid", 32'(bus_if.dout_valid), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_wr_cnt", 32'(bus_if.wr_cnt), 32'd0);
    check("rst_rd_cnt", 32'(bus_if.rd_cnt), 32'd0);
    check("rst_perr", 32'(bus_if.proto_err), 32'd0);

    // Full write held for two cycles: exactly one commit.
    do_write(20'h00005, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1);
    check("w1_wr_cnt", 32'(bus_if.wr_cnt), 32'd1);
    do_write(20'h00006, 16'h7777, 1'b0, 1'b0, 1, 1'b1);
    check("w2_wr_cnt", 32'(bus_if.wr_cnt), 32'(exp_wr));
    exp_q.push_back(16'hBEEF);
    do_read(20'h00005, 1'b0, 1'b0, lat);
    rd_release();
    check("r1_rd_cnt", 32'(bus_if.rd_cnt), 32'd1);

    // Lower-byte write, then a full read.
    do_write(20'h00005, 16'h1234, 1'b0, 1'b1, 1, 1'b1);
    exp_q.push_back(16'hBE34);
    do_read(20'h00005, 1'b0, 1'b0, lat);
    check("r2_latency", 32'(lat), 32'(RD_LAT));
    rd_release();
    check("r2_rd_cnt", 32'(bus_if.rd_cnt), 32'(exp_rd));

    // Upper-only read; an address change while driving must not disturb dout.
    exp_q.push_back(16'hBE00);
    do_read(20'h00005, 1'b1, 1'b0, lat);
    bus_if.addr = 20'h00006;
    repeat (2) @(negedge clk);
    check("r3_dout_hold", 32'(bus_if.dout), 32'h0000BE00);
    check("r3_valid_hold", 32'(bus_if.dout_valid), 32'd1);
    rd_release();

    // Aliasing: 0x405 maps onto word 5.
    do_write(20'h00405, 16'hA5A5, 1'b0, 1'b0, 1, 1'b1);
    exp_q.push_back(16'hA5A5);
    do_read(20'h00005, 1'b0, 1'b0, lat);
    rd_release();
    check("r4_rd_cnt", 32'(bus_if.rd_cnt), 32'd4);

    // A read abandoned during the latency wait is not counted.
    @(negedge clk);
    bus_if.addr = 20'h00005;
    bus_if.lb_n = 1'b0;
    bus_if.ub_n = 1'b0;
    bus_if.ce_n = 1'b0;
    bus_if.oe_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus_if.busy), 32'd1);
    bus_release();
    @(negedge clk);
    check("abort_idle", 32'(bus_if.busy), 32'd0);
    check("abort_valid", 32'(bus_if.dout_valid), 32'd0);
    check("abort_rd_cnt", 32'(bus_if.rd_cnt), 32'd4);
    check("perr_clean", 32'(bus_if.proto_err), 32'd0);

    // we and oe asserted together: the write commits, and the error flag sets when enabled.
    do_write(20'h00009, 16'h1111, 1'b0, 1'b0, 1, 1'b0);
    check("w6_wr_cnt", 32'(bus_if.wr_cnt), 32'(exp_wr));
    check("w6_perr", 32'(bus_if.proto_err), 32'(PERR_EXP));

    // Empty strobe: counted, but the RAM is left unchanged.
    do_write(20'h00005, 16'h0000, 1'b1, 1'b1, 1, 1'b1);
    check("empty_wr_cnt", 32'(bus_if.wr_cnt), 32'd6);
    exp_q.push_back(16'hA5A5);
    do_read(20'h00005, 1'b0, 1'b0, lat);
    rd_release();
    check("perr_sticky", 32'(bus_if.proto_err), 32'(PERR_EXP));

    // Asynchronous reset during the read wait.
    @(negedge clk);
    bus_if.addr = 20'h00005;
    bus_if.lb_n = 1'b0;
    bus_if.ub_n = 1'b0;
    bus_if.ce_n = 1'b0;
    bus_if.oe_n = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    check("mid_rst_valid", 32'(bus_if.dout_valid), 32'd0);
    check("mid_rst_dout", 32'(bus_if.dout), 32'd0);
    check("mid_rst_wr_cnt", 32'(bus_if.wr_cnt), 32'd0);
    check("mid_rst_perr", 32'(bus_if.proto_err), 32'd0);
    bus_release();
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 0;
    exp_q.push_back(16'hA5A5);
    do_read(20'h00005, 1'b0, 1'b0, lat);
    rd_release();
    exp_q.push_back(16'h1111);
    do_read(20'h00009, 1'b0, 1'b0, lat);
    check("r9_latency", 32'(lat), 32'(RD_LAT));
    rd_release();
    check("post_rst_rd_cnt", 32'(bus_if.rd_cnt), 32'(exp_rd));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
